bus_arb2: RTL and testbench
===========================

BUS_ARB2 -- requirements
Module: bus_arb2

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; TIMEOUT, default 255, maximum slave wait in cycles (1..255).
REQ-002 SHALL have ports (one per line):
 clk  in  1  clock, rising edge
 rst_n  in  1  reset, synchronous, active-low
 mN_enable  in  1  request/command strobe from master N (N=0,1)
 mN_wr_en  in  1  1=write, 0=read
 mN_addr  in  ADDR_WIDTH  address
 mN_i_data  in  DATA_WIDTH  write data
 mN_be  in  DATA_WIDTH/8  byte enables
 mN_ready  out  1  command done, to master N
 mN_o_data  out  DATA_WIDTH  read data, to master N
 mN_bus_err  out  1  error, to master N
 s_enable, s_wr_en, s_addr, s_i_data, s_be  out  (widths as master side)  to shared slave
 s_ready  in  1  from slave
 s_o_data  in  DATA_WIDTH  from slave
 s_bus_err  in  1  from slave
 grant  out  2  one-hot current owner, 00 = none

Function
REQ-003 SHALL share one slave port between two masters; protocol per side: enable high -> ready high -> enable low -> ready low before next command.
REQ-004 SHALL implement states IDLE, BUSY, RELEASE; owner and last-granted held in registers.
REQ-005 IDLE: a master requests when its mN_enable=1; grant is registered, so BUSY and grant are entered the cycle after the request is sampled.
REQ-006 Simultaneous requests SHALL be resolved round-robin: grant goes to the master not last granted; last-granted resets to 1, so m0 wins the first tie.
REQ-007 A single requester SHALL be granted regardless of last-granted.
REQ-008 In BUSY, s_enable, s_wr_en, s_addr, s_i_data and s_be SHALL be combinational copies of the owner's signals.
REQ-009 In BUSY, owner's mN_ready, mN_bus_err and mN_o_data SHALL equal s_ready, s_bus_err and s_o_data.
REQ-010 A non-owner SHALL see ready=0, bus_err=0, o_data=0 at all times.
REQ-011 Outside BUSY, s_enable, s_wr_en, s_addr and s_i_data SHALL be 0 and s_be SHALL be all ones, so the slave never flags a lane-0 error while idle.
REQ-012 BUSY -> RELEASE on the first cycle the owner's enable is sampled low, whether or not ready was seen (abort); s_enable falls the same cycle via REQ-008.
REQ-013 RELEASE -> IDLE when s_ready=0, then grant=00 and last-granted is updated.
REQ-014 A request already pending in RELEASE SHALL be granted at earliest one cycle after IDLE is entered; no back-to-back grant without an IDLE cycle.
REQ-015 An 8-bit wait counter SHALL clear on entry to BUSY and RELEASE, and increment each cycle in BUSY while s_ready=0.
REQ-016 When the counter reaches TIMEOUT in BUSY, a timeout flag SHALL set.
REQ-017 While the timeout flag is set, the owner SHALL see ready=1, bus_err=1, o_data=0 until it drops enable.
REQ-018 The timeout flag SHALL clear on leaving BUSY.
REQ-019 In RELEASE, the counter SHALL increment while s_ready=1; reaching TIMEOUT SHALL force IDLE.
REQ-020 The non-owner holding enable high SHALL wait indefinitely without corruption of the owner's transfer.

Reset
REQ-021 While rst_n=0 at a clock edge, the next state SHALL be IDLE, grant=00, last-granted=1, counter=0, timeout flag=0.
REQ-022 Reset SHALL take effect mid-transfer in any state; all outputs then follow REQ-010/REQ-011, so mN_ready=0, mN_bus_err=0, mN_o_data=0 and s_enable=0.

Verification
REQ-023 m0 read addr 0x02, slave returns 0x5A after 2 cycles -> s_enable rises 1 cycle after m0_enable; m0_ready=1, m0_o_data=0x5A; m1 outputs stay 0.
REQ-024 m0 and m1 raise enable in the same cycle, each repeats 3 commands -> grants alternate m0,m1,m0,m1,m0,m1, with one IDLE cycle between grants.
REQ-025 Slave holds s_ready=0, TIMEOUT=4 -> owner sees ready=1 and bus_err=1 on cycle 5 of BUSY; arbiter returns to IDLE after enable drops.
REQ-026 Owner drops enable before s_ready -> RELEASE, s_enable=0 the same cycle, IDLE once s_ready=0, and the other master is granted next.
REQ-027 rst_n=0 during BUSY with m1 owner -> next cycle grant=00, s_enable=0, s_be all ones; the first tie after reset is granted to m0.
REQ-028 m1 write with be=0 -> s_bus_err relayed only to m1; m0 remains 0.

Source files
------------

// File: rtl/bus_arb2.sv
// bus_arb2 -- two-master, one-slave bus arbiter.
//
// Two masters share one slave port. A master requests by raising mN_enable.
// The arbiter grants one of them (round-robin on a tie), then passes the
// owner's command straight through to the slave and the slave's response
// straight back. An 8-bit wait counter guards against a slave that never
// answers: once it reaches TIMEOUT, the owner is completed with bus_err.
// A second guard forces the arbiter back to IDLE if the slave never drops
// s_ready after the owner has released the bus.
//
// Ports
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   mN_enable/wr_en/addr/      command from master N (N = 0, 1)
//     i_data/be
//   mN_ready/o_data/bus_err    response to master N (all zero unless N owns the bus)
//   s_enable/wr_en/addr/       command to the shared slave
//     i_data/be
//   s_ready/o_data/bus_err     response from the shared slave
//   grant                      one-hot current owner, 2'b00 = none
module bus_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_enable,
  input  logic                    m0_wr_en,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_i_data,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_ready,
  output logic [DATA_WIDTH-1:0]   m0_o_data,
  output logic                    m0_bus_err,
  input  logic                    m1_enable,
  input  logic                    m1_wr_en,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_i_data,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  output logic                    m1_ready,
  output logic [DATA_WIDTH-1:0]   m1_o_data,
  output logic                    m1_bus_err,
  output logic                    s_enable,
  output logic                    s_wr_en,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_i_data,
  output logic [DATA_WIDTH/8-1:0] s_be,
  input  logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_o_data,
  input  logic                    s_bus_err,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = m0, 1 = m1
  logic        last_q, last_d;     // master granted most recently
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        owner_en;
  logic        winner;
  logic        busy;

  assign owner_en = owner_q ? m1_enable : m0_enable;
  assign busy     = (state_q == BUSY);
  assign grant    = grant_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    // On a tie the master that was not granted last wins; otherwise the
    // lone requester wins regardless of history.
    winner  = (m0_enable && m1_enable) ? ~last_q : m1_enable;

    case (state_q)
      IDLE: begin
        if (m0_enable || m1_enable) begin
          state_d = BUSY;
          owner_d = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          cnt_d   = 8'd0;
          tmo_d   = 1'b0;
        end
      end
      BUSY: begin
        if (!owner_en) begin
          // Owner is done or has aborted; the slave command is already
          // withdrawn combinationally this cycle.
          state_d = RELEASE;
          cnt_d   = 8'd0;
          tmo_d   = 1'b0;
        end else if (!s_ready && !tmo_q) begin
          // Flag is set from the next count so the owner sees the forced
          // completion on the cycle the count equals TIMEOUT.
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            tmo_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!s_ready) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = owner_q;
        end else begin
          // Slave stuck with ready high: give up after TIMEOUT cycles.
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            state_d = IDLE;
            grant_d = 2'b00;
            last_d  = owner_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Slave side: owner's command while BUSY, otherwise a quiet bus with all
  // byte lanes enabled so the slave never reports a spurious lane error.
  assign s_enable = busy && owner_en;
  assign s_wr_en  = busy && (owner_q ? m1_wr_en : m0_wr_en);
  assign s_addr   = busy ? (owner_q ? m1_addr : m0_addr) : '0;
  assign s_i_data = busy ? (owner_q ? m1_i_data : m0_i_data) : '0;
  assign s_be     = busy ? (owner_q ? m1_be : m0_be) : '1;

  // Master side: only the owner, and only while BUSY, sees the slave.
  logic [1:0]            rdy_vec;
  logic [1:0]            err_vec;
  logic [DATA_WIDTH-1:0] rd_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic sel;
    assign sel         = busy && (owner_q == 1'(gi));
    assign rdy_vec[gi] = sel && (tmo_q || s_ready);
    assign err_vec[gi] = sel && (tmo_q || s_bus_err);
    assign rd_vec[gi]  = (sel && !tmo_q) ? s_o_data : '0;
  end

  assign m0_ready   = rdy_vec[0];
  assign m0_bus_err = err_vec[0];
  assign m0_o_data  = rd_vec[0];
  assign m1_ready   = rdy_vec[1];
  assign m1_bus_err = err_vec[1];
  assign m1_o_data  = rd_vec[1];

endmodule

// File: tb/tb_bus_arb2.sv
// Testbench for bus_arb2: directed commands from both masters against a
// small behavioural slave; responses and grant order go through scoreboards.
module tb_bus_arb2;

  logic        clk;
  logic        rst_n;
  logic        m0_enable, m0_wr_en, m1_enable, m1_wr_en;
  logic [31:0] m0_addr, m0_i_data, m1_addr, m1_i_data;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ready, m0_bus_err, m1_ready, m1_bus_err;
  logic [31:0] m0_o_data, m1_o_data;
  logic        s_enable, s_wr_en;
  logic [31:0] s_addr, s_i_data;
  logic [3:0]  s_be;
  logic        s_ready, s_bus_err;
  logic [31:0] s_o_data;
  logic [1:0]  grant;

  bus_arb2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_enable(m0_enable), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr),
    .m0_i_data(m0_i_data), .m0_be(m0_be), .m0_ready(m0_ready),
    .m0_o_data(m0_o_data), .m0_bus_err(m0_bus_err),
    .m1_enable(m1_enable), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr),
    .m1_i_data(m1_i_data), .m1_be(m1_be), .m1_ready(m1_ready),
    .m1_o_data(m1_o_data), .m1_bus_err(m1_bus_err),
    .s_enable(s_enable), .s_wr_en(s_wr_en), .s_addr(s_addr),
    .s_i_data(s_i_data), .s_be(s_be), .s_ready(s_ready),
    .s_o_data(s_o_data), .s_bus_err(s_bus_err), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t       q0[$];
  rsp_t       q1[$];
  logic [1:0] gq[$];
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 0;

  function automatic rsp_t mk(input logic err, input logic [31:0] data);
    rsp_t r;
    r.err  = err;
    r.data = data;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Behavioural slave: read data = addr ^ 0x58, writes return 0, a write with
  // no byte lanes enabled is answered with bus_err. slv_hang withholds ready.
  bit          slv_hang = 0;
  int          slv_lat = 2;
  int          slv_w = 0;
  logic [31:0] slv_wdata = '0;

  initial begin
    logic        en, wr;
    logic [31:0] a, d;
    logic [3:0]  b;
    s_ready = 1'b0; s_bus_err = 1'b0; s_o_data = '0;
    forever begin
      @(posedge clk);
      en = s_enable; wr = s_wr_en; a = s_addr; d = s_i_data; b = s_be;
      #1;
      if (!en) begin
        s_ready = 1'b0; s_bus_err = 1'b0; s_o_data = '0; slv_w = 0;
      end else if (!s_ready && !slv_hang) begin
        slv_w++;
        if (slv_w >= slv_lat) begin
          s_ready   = 1'b1;
          s_bus_err = wr && (b == 4'h0);
          s_o_data  = wr ? 32'h0 : (a ^ 32'h58);
          if (wr) slv_wdata = d;
        end
      end
    end
  end

  // Monitor: response scoreboard on ready rising edges, grant-order
  // scoreboard on each new grant, and per-cycle isolation checks.
  initial begin
    logic       p0r, p1r;
    logic [1:0] pg;
    rsp_t       r;
    p0r = 1'b0; p1r = 1'b0; pg = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m0_ready && !p0r) begin
          if (q0.size() == 0) fail_now("m0_unexpected_ready");
          else begin
            r = q0.pop_front();
            chk("m0_rsp_data", m0_o_data, r.data);
            chk("m0_rsp_err", m0_bus_err, r.err);
            $display("m0 response data=%h err=%0d", m0_o_data, m0_bus_err);
          end
        end
        if (m1_ready && !p1r) begin
          if (q1.size() == 0) fail_now("m1_unexpected_ready");
          else begin
            r = q1.pop_front();
            chk("m1_rsp_data", m1_o_data, r.data);
            chk("m1_rsp_err", m1_bus_err, r.err);
            $display("m1 response data=%h err=%0d", m1_o_data, m1_bus_err);
          end
        end
        if (grant != pg && grant != 2'b00) begin
          chk("grant_gap", pg, 2'b00);
          if (gq.size() == 0) fail_now("grant_unexpected");
          else chk("grant_order", grant, gq.pop_front());
          $display("grant -> %b", grant);
        end
        if (!grant[0]) begin
          chk("m0_idle_flags", {m0_ready, m0_bus_err}, 2'b00);
          chk("m0_idle_data", m0_o_data, 32'h0);
        end
        if (!grant[1]) begin
          chk("m1_idle_flags", {m1_ready, m1_bus_err}, 2'b00);
          chk("m1_idle_data", m1_o_data, 32'h0);
        end
        if (grant == 2'b00) begin
          chk("idle_s_enable", s_enable, 1'b0);
          chk("idle_s_be", s_be, 4'hF);
          chk("idle_s_addr", s_addr, 32'h0);
        end
      end
      p0r = m0_ready; p1r = m1_ready; pg = grant;
    end
  end

  task automatic set_m(input int m, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (m == 0) begin
      m0_enable = en; m0_wr_en = wr; m0_addr = a; m0_i_data = d; m0_be = b;
    end else begin
      m1_enable = en; m1_wr_en = wr; m1_addr = a; m1_i_data = d; m1_be = b;
    end
  endtask

  task automatic wait_ready(input int m, input logic val, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (((m == 0) ? m0_ready : m1_ready) == val) return;
    end
    fail_now(name);
  endtask

  task automatic wait_grant(input logic [1:0] val, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (grant == val) return;
    end
    fail_now(name);
  endtask

  // One full handshake: enable -> ready -> enable low -> ready low.
  task automatic m_cmd(input int m, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    set_m(m, 1'b1, wr, a, d, b);
    wait_ready(m, 1'b1, $sformatf("m%0d_ready_rise_timeout", m));
    @(posedge clk); #1;
    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ready(m, 1'b0, $sformatf("m%0d_ready_fall_timeout", m));
  endtask

  logic [31:0] a0_tab [3];
  logic [31:0] e0_tab [3];
  logic [31:0] a1_tab [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a0_tab = '{32'h10, 32'h14, 32'h18};
    e0_tab = '{32'h48, 32'h4C, 32'h40};
    a1_tab = '{32'h20, 32'h24, 32'h28};
    rst_n = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_enable", s_enable, 1'b0);
    chk("rst_s_be", s_be, 4'hF);
    chk("rst_m_ready", {m0_ready, m1_ready}, 2'b00);
    $display("reset state checked");
    mon_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // m0 read of 0x02, slave answers 0x5A after 2 cycles
    q0.push_back(mk(1'b0, 32'h5A));
    gq.push_back(2'b01);
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h02, 32'h0, 4'hF);
    @(negedge clk);
    chk("rd_s_enable_cyc0", s_enable, 1'b0);
    chk("rd_grant_cyc0", grant, 2'b00);
    @(negedge clk);
    chk("rd_s_enable_cyc1", s_enable, 1'b1);
    chk("rd_s_addr", s_addr, 32'h02);
    chk("rd_grant_cyc1", grant, 2'b01);
    @(negedge clk);
    chk("rd_ready_cyc2", m0_ready, 1'b0);
    @(negedge clk);
    chk("rd_ready_cyc3", m0_ready, 1'b1);
    chk("rd_data_cyc3", m0_o_data, 32'h5A);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ready(0, 1'b0, "rd_ready_fall_timeout");
    $display("m0 read 0x02 done");

    // m1 write with no byte lanes: error goes to m1 only
    q1.push_back(mk(1'b1, 32'h0));
    gq.push_back(2'b10);
    m_cmd(1, 1'b1, 32'h30, 32'hDEADBEEF, 4'h0);
    chk("wr_s_i_data", slv_wdata, 32'hDEADBEEF);
    $display("m1 write be=0 done");

    // Simultaneous requests, three commands each: strict alternation
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, e0_tab[i]));
      q1.push_back(mk(1'b0, 32'h0));
      gq.push_back(2'b01);
      gq.push_back(2'b10);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) m_cmd(0, 1'b0, a0_tab[i], 32'h0, 4'hF);
      end
      begin
        for (int i = 0; i < 3; i++) m_cmd(1, 1'b1, a1_tab[i], 32'h1000 + i, 4'hF);
      end
    join
    $display("round-robin burst done");

    // Silent slave: timeout completes the owner with bus_err on BUSY cycle 5
    @(negedge clk);
    slv_hang = 1;
    q0.push_back(mk(1'b1, 32'h0));
    gq.push_back(2'b01);
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
    wait_grant(2'b01, "tmo_grant_timeout");
    repeat (3) @(negedge clk);
    chk("tmo_ready_cyc4", m0_ready, 1'b0);
    @(negedge clk);
    chk("tmo_ready_cyc5", m0_ready, 1'b1);
    chk("tmo_err_cyc5", m0_bus_err, 1'b1);
    chk("tmo_data_cyc5", m0_o_data, 32'h0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_grant(2'b00, "tmo_idle_timeout");
    slv_hang = 0;
    $display("timeout transfer done");

    // Abort: m0 drops enable before ready, m1 is granted next
    @(negedge clk);
    slv_hang = 1;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    q1.push_back(mk(1'b0, 32'h38));
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
    wait_grant(2'b01, "abort_grant_timeout");
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("abort_s_enable", s_enable, 1'b0);
    chk("abort_grant_busy", grant, 2'b01);
    slv_hang = 0;
    @(negedge clk);
    chk("abort_grant_release", grant, 2'b01);
    @(negedge clk);
    chk("abort_grant_idle", grant, 2'b00);
    @(negedge clk);
    chk("abort_grant_m1", grant, 2'b10);
    wait_ready(1, 1'b1, "abort_m1_ready_timeout");
    @(posedge clk); #1;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ready(1, 1'b0, "abort_m1_fall_timeout");
    $display("abort and handover done");

    // Reset while m1 owns the bus; first tie afterwards goes to m0
    @(negedge clk);
    slv_hang = 1;
    gq.push_back(2'b10);
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    wait_grant(2'b10, "rstbusy_grant_timeout");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstbusy_grant", grant, 2'b00);
    chk("rstbusy_s_enable", s_enable, 1'b0);
    chk("rstbusy_s_be", s_be, 4'hF);
    chk("rstbusy_m1_ready", m1_ready, 1'b0);
    slv_hang = 0;
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    q0.push_back(mk(1'b0, 32'h08));
    q1.push_back(mk(1'b0, 32'h18));
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF);
    wait_ready(0, 1'b1, "rstbusy_m0_ready_timeout");
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ready(0, 1'b0, "rstbusy_m0_fall_timeout");
    wait_ready(1, 1'b1, "rstbusy_m1_ready_timeout");
    @(posedge clk); #1;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
    wait_ready(1, 1'b0, "rstbusy_m1_fall_timeout");
    $display("reset during transfer done");

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("grant_q_drained", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
